// File: rtl/mod_counter_updown.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mod_counter_updown
// Modulo-N up/down counter with synchronous parallel load, wrap or one-shot
// behaviour at the terminal value, and a combinational terminal-count output
// (tc) meant to drive the enable of the next stage in a cascade.
//
// Control priority on every rising edge: reset > load > enable > hold.
//
// Cascade handshake: tc is a single-cycle "step taken at terminal" strobe.
// It is high only in a cycle where this stage is enabled, running, not
// being loaded or reset, and sitting on the terminal value for the current
// direction. The next stage samples tc as its enable on the same edge that
// this stage wraps, so both stages move together.
// ---------------------------------------------------------------------------
module mod_counter_updown #(
   parameter int N = 10,
   parameter int A = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         up,
   input  logic         mode,
   input  logic         load,
   input  logic [A-1:0] load_value,
   output logic [A-1:0] counter,
   output logic         tc,
   output logic         wrap,
   output logic         done,
   output logic [0:0]   dbg_state_o
);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   generate
      if (N < 2) begin : g_bad_modulus
         $error("mod_counter_updown: N must be at least 2");
      end
      if (A < $clog2(N)) begin : g_bad_width
         $error("mod_counter_updown: A is too narrow to hold N-1");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   // RUN counts; DONE freezes the counter until a load or reset.
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_DONE = 1'b1;

   // Largest legal count. N-1 always fits in A bits.
   localparam logic [A-1:0] MAX_VAL = A'(N - 1);

   // Modulus one bit wider so N == 2**A still compares correctly.
   localparam logic [A:0]   MOD_W   = (A + 1)'(N);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [A-1:0] count_q, count_d;
   logic [0:0]   state_q, state_d;
   logic         wrap_q,  wrap_d;
   logic         done_q,  done_d;

   // ------------------------------------------------------------------------
   // Helper decodes
   // ------------------------------------------------------------------------
   logic         at_term;       // counter sits on terminal for current direction
   logic         step_ok;       // a counting step would be taken this edge
   logic [A-1:0] load_clamped;  // load_value limited to 0..N-1
   logic [A-1:0] count_inc;
   logic [A-1:0] count_dec;

   // Terminal detection, load clamping and the two step candidates.
   always_comb begin
      at_term      = up ? (count_q == MAX_VAL) : (count_q == '0);
      step_ok      = enable & (state_q == ST_RUN) & ~load & ~reset;
      load_clamped = ({1'b0, load_value} >= MOD_W) ? MAX_VAL : load_value;
      count_inc    = count_q + A'(1);
      count_dec    = count_q - A'(1);
   end

   // Next-state logic: load first, then counting, otherwise hold.
   always_comb begin
      count_d = count_q;
      state_d = state_q;
      wrap_d  = 1'b0;
      done_d  = done_q;

      if (load) begin
         // Load overrides any step, even one at terminal: no wrap, no done.
         count_d = load_clamped;
         state_d = ST_RUN;
         done_d  = 1'b0;
      end else if (enable && (state_q == ST_RUN)) begin
         if (!at_term) begin
            count_d = up ? count_inc : count_dec;
         end else if (!mode) begin
            // Free-running: jump to the opposite end and flag the wrap.
            count_d = up ? '0 : MAX_VAL;
            wrap_d  = 1'b1;
         end else begin
            // One-shot: hold on the terminal value and park in DONE.
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
      end
      // In DONE, or with enable low, everything except wrap holds.
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         state_q <= ST_RUN;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         state_q <= state_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // tc is combinational so a downstream stage steps on the same edge.
   assign tc          = step_ok & at_term;
   assign counter     = count_q;
   assign wrap        = wrap_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

   // ------------------------------------------------------------------------
   // Embedded properties
   // ------------------------------------------------------------------------
`ifndef SYNTHESIS
   // The count never leaves 0..N-1.
   a_in_range : assert property (@(posedge clk) disable iff (reset)
      ({1'b0, counter} < MOD_W));

   // done mirrors the DONE state.
   a_done_state : assert property (@(posedge clk) disable iff (reset)
      (done == (state_q == ST_DONE)));

   // A load never produces a wrap pulse.
   a_load_no_wrap : assert property (@(posedge clk)
      (load |=> !wrap));
`endif

endmodule

// File: tb/tb_mod_counter_updown.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mod_counter_updown
// Directed scenarios with literal expectations, a two-digit decimal cascade,
// then a randomized run. A behavioural model tracks count/done/wrap as plain
// integers and a single compare process checks every cycle.
// ---------------------------------------------------------------------------
module tb_mod_counter_updown;

   localparam int N = 10;
   localparam int A = 4;

   // ------------------------------------------------------------------------
   // Clock / reset block
   // ------------------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic         up = 1'b1;
   logic         mode = 1'b0;
   logic         load = 1'b0;
   logic [A-1:0] load_value = '0;

   logic [A-1:0] counter;
   logic         tc, wrap, done;
   logic [0:0]   dbg_state;

   // Cascade stimulus and outputs
   logic         c_reset = 1'b1;
   logic         c_en = 1'b0;
   logic [A-1:0] lo_cnt, hi_cnt;
   logic         lo_tc, lo_wrap, lo_done, hi_tc, hi_wrap, hi_done;
   logic [0:0]   lo_state, hi_state;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;
   bit casc_chk = 1'b0;

   mod_counter_updown #(.N(N), .A(A)) dut (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .mode(mode),
      .load(load), .load_value(load_value), .counter(counter), .tc(tc),
      .wrap(wrap), .done(done), .dbg_state_o(dbg_state)
   );

   mod_counter_updown #(.N(10), .A(4)) u_lo (
      .clk(clk), .reset(c_reset), .enable(c_en), .up(1'b1), .mode(1'b0),
      .load(1'b0), .load_value(4'd0), .counter(lo_cnt), .tc(lo_tc),
      .wrap(lo_wrap), .done(lo_done), .dbg_state_o(lo_state)
   );

   mod_counter_updown #(.N(10), .A(4)) u_hi (
      .clk(clk), .reset(c_reset), .enable(lo_tc), .up(1'b1), .mode(1'b0),
      .load(1'b0), .load_value(4'd0), .counter(hi_cnt), .tc(hi_tc),
      .wrap(hi_wrap), .done(hi_done), .dbg_state_o(hi_state)
   );

   // ------------------------------------------------------------------------
   // Scoreboard helper
   // ------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: count as an integer modulo N, done as a stop flag
   // ------------------------------------------------------------------------
   int m_cnt  = 0;
   bit m_done = 1'b0;
   bit m_wrap = 1'b0;
   int m_casc = 0;   // two-digit cascade value, 0..99

   always @(posedge clk) begin
      int term;
      int step;
      term = up ? N - 1 : 0;
      step = up ? 1 : -1;
      if (reset) begin
         m_cnt = 0; m_done = 1'b0; m_wrap = 1'b0;
      end else if (load) begin
         m_cnt  = (int'(load_value) > N - 1) ? N - 1 : int'(load_value);
         m_done = 1'b0; m_wrap = 1'b0;
      end else if (enable && !m_done) begin
         if (m_cnt == term && mode) begin
            m_done = 1'b1; m_wrap = 1'b0;
         end else begin
            m_wrap = (m_cnt == term);
            m_cnt  = (m_cnt + N + step) % N;
         end
      end else begin
         m_wrap = 1'b0;
      end

      if (c_reset)   m_casc = 0;
      else if (c_en) m_casc = (m_casc + 1) % 100;
   end

   // Compare process: outputs sampled on the falling edge.
   always @(negedge clk) begin
      bit exp_tc;
      if (chk_en) begin
         exp_tc = enable && !reset && !load && !m_done && (m_cnt == (up ? N - 1 : 0));
         check("model_counter", 32'(counter), 32'(m_cnt));
         check("model_wrap",    32'(wrap),    32'(m_wrap));
         check("model_done",    32'(done),    32'(m_done));
         check("model_tc",      32'(tc),      32'(exp_tc));
      end
      if (casc_chk) begin
         check("casc_lo", 32'(lo_cnt), 32'(m_casc % 10));
         check("casc_hi", 32'(hi_cnt), 32'(m_casc / 10));
      end
   end

   // ------------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      // Reset state
      tick(1);
      chk_en = 1'b1;
      check("rst_counter", 32'(counter), 0);
      check("rst_wrap",    32'(wrap),    0);
      check("rst_done",    32'(done),    0);

      // Up count, wrap mode: 0..9,0..9,0..4 over 25 edges
      reset = 1'b0; enable = 1'b1; up = 1'b1; mode = 1'b0;
      #1;
      check("up_tc_at_0", 32'(tc), 0);
      tick(9);
      check("up_at_9",     32'(counter), 9);
      check("up_tc_at_9",  32'(tc), 1);
      tick(1);
      check("up_wrap_cnt", 32'(counter), 0);
      check("up_wrap",     32'(wrap), 1);
      tick(1);
      check("up_after_wrap_cnt", 32'(counter), 1);
      check("up_wrap_clear",     32'(wrap), 0);
      tick(14);
      check("up_25_edges", 32'(counter), 5);

      // Down count from reset: 0 -> 9 -> ... -> 0 -> 9
      reset = 1'b1; tick(1);
      reset = 1'b0; up = 1'b0;
      tick(1);
      check("dn_first",      32'(counter), 9);
      check("dn_first_wrap", 32'(wrap), 1);
      tick(9);
      check("dn_at_0",      32'(counter), 0);
      check("dn_tc_at_0",   32'(tc), 1);
      check("dn_wrap_low",  32'(wrap), 0);
      tick(1);
      check("dn_second",      32'(counter), 9);
      check("dn_second_wrap", 32'(wrap), 1);

      // One-shot: load 7, count 8, 9, stop
      enable = 1'b0; up = 1'b1; mode = 1'b1; load = 1'b1; load_value = 4'd7;
      tick(1);
      check("os_load7", 32'(counter), 7);
      load = 1'b0; enable = 1'b1;
      tick(2);
      check("os_at_9",    32'(counter), 9);
      check("os_done_0",  32'(done), 0);
      check("os_tc",      32'(tc), 1);
      tick(1);
      check("os_hold_9",  32'(counter), 9);
      check("os_done_1",  32'(done), 1);
      check("os_no_wrap", 32'(wrap), 0);
      up = 1'b0; mode = 1'b0;
      tick(2);
      check("os_frozen",  32'(counter), 9);
      check("os_done_hold", 32'(done), 1);
      load = 1'b1; load_value = 4'd3;
      tick(1);
      check("os_reload",  32'(counter), 3);
      check("os_done_clr", 32'(done), 0);
      load = 1'b0;

      // Clamp and load-over-terminal
      enable = 1'b0; load = 1'b1; load_value = 4'd15;
      tick(1);
      check("clamp_15", 32'(counter), 9);
      up = 1'b1; mode = 1'b0; enable = 1'b1; load_value = 4'd9;
      #1;
      check("load_tc_low", 32'(tc), 0);
      tick(1);
      check("load_term_cnt",  32'(counter), 9);
      check("load_term_wrap", 32'(wrap), 0);
      load = 1'b0;

      // Reset while in DONE
      mode = 1'b1;
      tick(1);
      check("pre_rst_done", 32'(done), 1);
      reset = 1'b1;
      tick(1);
      check("rst_done_cnt",  32'(counter), 0);
      check("rst_done_done", 32'(done), 0);
      check("rst_done_wrap", 32'(wrap), 0);
      reset = 1'b0; mode = 1'b0;
      tick(1);
      check("resume_1", 32'(counter), 1);
      tick(1);
      check("resume_2", 32'(counter), 2);

      // Reset while counting at 5, and tc suppressed during reset at 9
      load = 1'b1; load_value = 4'd5; tick(1); load = 1'b0;
      reset = 1'b1;
      tick(1);
      check("rst_mid_cnt", 32'(counter), 0);
      reset = 1'b0; load = 1'b1; load_value = 4'd9; tick(1); load = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_tc_low", 32'(tc), 0);
      tick(1);
      check("rst_at9_cnt",  32'(counter), 0);
      check("rst_at9_wrap", 32'(wrap), 0);
      reset = 1'b0;
      tick(2);
      check("rst_resume", 32'(counter), 2);

      // Cascade: 105 enabled edges gives 105 mod 100 = 05
      enable = 1'b0;
      tick(1);
      casc_chk = 1'b1;
      c_reset = 1'b0; c_en = 1'b1;
      tick(105);
      check("casc105_lo", 32'(lo_cnt), 5);
      check("casc105_hi", 32'(hi_cnt), 0);
      c_en = 1'b0;
      tick(3);
      check("casc_hold_lo", 32'(lo_cnt), 5);
      check("casc_hold_hi", 32'(hi_cnt), 0);

      // Randomized run
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 63) == 0);
         load       = ($urandom_range(0, 15) == 0);
         load_value = A'($urandom_range(0, 15));
         enable     = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0)  up = ~up;
         if ($urandom_range(0, 31) == 0) mode = ~mode;
         c_en       = 1'($urandom_range(0, 1));
         tick(1);
      end

      reset = 1'b1; enable = 1'b0; load = 1'b0; c_en = 1'b0;
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
